// File: rtl/esp_link_tx.sv
// rtl/esp_link_tx.sv - FPGA->ESP serial transmitter: byte FIFO feeding a start/8N/opt-parity/stop framer.
module esp_link_tx #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 1_000_000,
    parameter int FIFO_DEPTH = 4,
    parameter bit PARITY_EN  = 1'b0
) (
    input  logic                               clk_100mhz,
    input  logic                               rst,
    input  logic [7:0]                         tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    output logic                               tx_out,
    output logic                               busy,
    output logic                               frame_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
    localparam int CPB   = CLK_HZ / BAUD;
    localparam int CNT_W = (CPB > 2) ? $clog2(CPB) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [CW-1:0]    FULL     = CW'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [2:0]       state;
    logic [2:0]       state_n;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_n;
    logic [7:0]       shift;
    logic [7:0]       shift_n;
    logic             par_bit;
    logic             par_n;
    logic             push;
    logic             pop;
    logic             bit_end;
    logic             non_empty;
    logic [7:0]       head;
    logic             tx_n;

    assign tx_ready  = !rst && (fifo_count != FULL);
    assign push      = tx_valid && tx_ready;
    assign non_empty = (fifo_count != '0);
    assign head      = mem[rd_ptr];
    assign bit_end   = (baud_cnt == CNT_LAST);

    always_comb begin
        state_n = state;
        bit_n   = bit_idx;
        shift_n = shift;
        par_n   = par_bit;
        pop     = 1'b0;
        cnt_n   = (state == ST_IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
        case (state)
            ST_IDLE: begin
                if (non_empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    par_n   = ^head;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_n = ST_DATA;
                    bit_n   = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_n = shift >> 1;
                    if (bit_idx == 3'd7) begin
                        state_n = PARITY_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                // Chaining straight into START keeps back-to-back frames gapless.
                if (bit_end) begin
                    if (non_empty) begin
                        pop     = 1'b1;
                        shift_n = head;
                        par_n   = ^head;
                        state_n = ST_START;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = shift_n[0];
            ST_PARITY: tx_n = par_n;
            default:   tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // Outputs are registered from next-state values so they line up with state.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            shift      <= 8'h00;
            par_bit    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= cnt_n;
            bit_idx    <= bit_n;
            shift      <= shift_n;
            par_bit    <= par_n;
            tx_out     <= tx_n;
            busy       <= (state_n != ST_IDLE);
            frame_done <= (state_n == ST_STOP) && (cnt_n == CNT_LAST);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_esp_link_tx.sv
// tb/tb_esp_link_tx.sv - bench for esp_link_tx: frame-level model, loopback sampler, directed vectors.
module tb_esp_link_tx;
    typedef struct {
        int         start;
        logic [7:0] b;
    } frame_t;

    logic       clk = 1'b0;
    logic       rs  [3];
    logic       tv  [3];
    logic [7:0] td  [3];
    logic       txr [3];
    logic       txo [3];
    logic       bsy [3];
    logic       fd  [3];
    logic [2:0] fc  [3];

    always #5 clk = ~clk;

    esp_link_tx #(.CLK_HZ(100_000_000), .BAUD(25_000_000), .FIFO_DEPTH(4), .PARITY_EN(1'b0)) dut0 (
        .clk_100mhz(clk), .rst(rs[0]), .tx_data(td[0]), .tx_valid(tv[0]), .tx_ready(txr[0]),
        .tx_out(txo[0]), .busy(bsy[0]), .frame_done(fd[0]), .fifo_count(fc[0]));
    esp_link_tx #(.CLK_HZ(100_000_000), .BAUD(25_000_000), .FIFO_DEPTH(4), .PARITY_EN(1'b1)) dut1 (
        .clk_100mhz(clk), .rst(rs[1]), .tx_data(td[1]), .tx_valid(tv[1]), .tx_ready(txr[1]),
        .tx_out(txo[1]), .busy(bsy[1]), .frame_done(fd[1]), .fifo_count(fc[1]));
    esp_link_tx #(.CLK_HZ(100_000_000), .BAUD(1_000_000), .FIFO_DEPTH(4), .PARITY_EN(1'b0)) dut2 (
        .clk_100mhz(clk), .rst(rs[2]), .tx_data(td[2]), .tx_valid(tv[2]), .tx_ready(txr[2]),
        .tx_out(txo[2]), .busy(bsy[2]), .frame_done(fd[2]), .fifo_count(fc[2]));

    int         cpb [3];
    int         par [3];
    frame_t     fq  [3][$];
    logic [7:0] pend[3][$];
    logic [7:0] rxq [3][$];
    logic       rxp [3][$];
    logic [7:0] sent[$];
    int         last_end[3];
    int         mcnt[3];
    int         acc_k[3];
    int         s_k[3];
    int         last_len[3];
    int         maxc[3];
    bit         en[3];
    bit         s_act[3];
    bit         prev_l[3];
    bit         gap_rand[3];
    logic       rst_req[3];
    logic [7:0] s_byte[3];
    logic       s_par[3];
    logic [10:0] wave[3];
    logic [10:0] last_wave[3];
    int         cyc;
    int         checks;
    int         failures;

    task automatic chk(input string name, input int inst, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", name, inst, cyc, act, exp);
        end
    endtask

    // Expected outputs follow from the frame schedule alone: which frame covers cycle k and which bit slot k falls in.
    task automatic compare_inst(input int i, input int k);
        int         len;
        int         off;
        int         idx;
        int         e_tx;
        int         e_busy;
        int         e_done;
        int         e_cnt;
        int         e_rdy;
        int         j;
        bit         in_fr;
        bit         l;
        logic [7:0] b;
        len = (10 + par[i]) * cpb[i];
        while (fq[i].size() > 0 && fq[i][0].start + len - 1 < k) void'(fq[i].pop_front());
        in_fr = (fq[i].size() > 0) && (fq[i][0].start <= k);
        e_cnt = fq[i].size() - (in_fr ? 1 : 0);
        e_tx = 1; e_busy = 0; e_done = 0;
        if (in_fr) begin
            b   = fq[i][0].b;
            off = k - fq[i][0].start;
            idx = off / cpb[i];
            if (idx == 0) e_tx = 0;
            else if (idx <= 8) e_tx = int'(b[idx-1]);
            else if (idx == 9 && par[i] == 1) e_tx = int'(^b);
            e_busy = 1;
            e_done = (off == len - 1) ? 1 : 0;
        end
        e_rdy = (!rs[i] && e_cnt != 4) ? 1 : 0;
        mcnt[i] = e_cnt;
        chk("tx_out", i, int'(txo[i]), e_tx);
        chk("busy", i, int'(bsy[i]), e_busy);
        chk("frame_done", i, int'(fd[i]), e_done);
        chk("fifo_count", i, int'(fc[i]), e_cnt);
        chk("tx_ready", i, int'(txr[i]), e_rdy);
        if (int'(fc[i]) > maxc[i]) maxc[i] = int'(fc[i]);
        l = txo[i];
        if (!s_act[i] && prev_l[i] && !l) begin
            s_act[i] = 1'b1;
            s_k[i]   = k;
            wave[i]  = '0;
        end
        if (s_act[i]) begin
            off = k - s_k[i];
            if (off % cpb[i] == cpb[i] / 2) begin
                j = off / cpb[i];
                wave[i] = {wave[i][9:0], l};
                if (j >= 1 && j <= 8) s_byte[i][j-1] = l;
                if (j == 9 && par[i] == 1) s_par[i] = l;
                if (j == 9 + par[i]) begin
                    rxq[i].push_back(s_byte[i]);
                    rxp[i].push_back(s_par[i]);
                    last_wave[i] = wave[i];
                    s_act[i] = 1'b0;
                end
            end
        end
        if (fd[i]) last_len[i] = k - s_k[i] + 1;
        prev_l[i] = l;
    endtask

    task automatic model_edge(input int i, input int n);
        int     len;
        int     st;
        frame_t f;
        len = (10 + par[i]) * cpb[i];
        if (rs[i]) begin
            fq[i].delete();
            last_end[i] = 0;
            en[i]       = 1'b1;
            s_act[i]    = 1'b0;
            prev_l[i]   = 1'b1;
            mcnt[i]     = 0;
        end else if (en[i] && tv[i] && mcnt[i] != 4) begin
            st = (n + 1 > last_end[i] + 1) ? n + 1 : last_end[i] + 1;
            last_end[i] = st + len - 1;
            f.start = st;
            f.b     = td[i];
            fq[i].push_back(f);
            acc_k[i] = n;
            void'(pend[i].pop_front());
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 3; i++) if (en[i]) compare_inst(i, cyc);
        for (int i = 0; i < 3; i++) begin
            rs[i] = rst_req[i];
            tv[i] = (pend[i].size() > 0) && (!gap_rand[i] || $urandom_range(0, 3) != 0);
            td[i] = (pend[i].size() > 0) ? pend[i][0] : 8'h00;
        end
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) model_edge(i, cyc);
    endtask

    task automatic wait_rx(input int i, input int n, input int budget);
        for (int t = 0; t < budget && rxq[i].size() < n; t++) step();
        chk("rx_count", i, rxq[i].size(), n);
    endtask

    initial begin
        cpb = '{4, 4, 100};
        par = '{0, 1, 0};
        cyc = 0; checks = 0; failures = 0;
        for (int i = 0; i < 3; i++) begin
            rs[i] = 1'b1; tv[i] = 1'b0; td[i] = 8'h00; rst_req[i] = 1'b1;
            en[i] = 1'b0; s_act[i] = 1'b0; prev_l[i] = 1'b1; gap_rand[i] = 1'b0;
            last_end[i] = 0; mcnt[i] = 0; acc_k[i] = 0; s_k[i] = 0; last_len[i] = 0; maxc[i] = 0;
            s_byte[i] = 8'h00; s_par[i] = 1'b0; wave[i] = '0; last_wave[i] = '0;
        end
        repeat (3) step();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_tx_out", i, int'(txo[i]), 1);
            chk("reset_busy", i, int'(bsy[i]), 0);
            chk("reset_count", i, int'(fc[i]), 0);
            chk("reset_ready", i, int'(txr[i]), 0);
            rst_req[i] = 1'b0;
        end
        repeat (3) step();

        // Single 0xA5: line 0,1,0,1,0,0,1,0,1,1
        pend[0].push_back(8'hA5);
        wait_rx(0, 1, 200);
        chk("a5_wave", 0, int'(last_wave[0][9:0]), 32'b0101001011);
        chk("a5_byte", 0, int'(rxq[0][0]), 32'hA5);
        chk("start_latency_edges", 0, s_k[0] - acc_k[0] + 1, 2);
        repeat (6) step();
        chk("frame_done_cycle", 0, last_len[0], 40);
        #1;
        chk("busy_after", 0, int'(bsy[0]), 0);

        // Back-to-back 00 FF 55
        pend[0].push_back(8'h00); pend[0].push_back(8'hFF); pend[0].push_back(8'h55);
        wait_rx(0, 4, 400);
        chk("b2b_0", 0, int'(rxq[0][1]), 32'h00);
        chk("b2b_1", 0, int'(rxq[0][2]), 32'hFF);
        chk("b2b_2", 0, int'(rxq[0][3]), 32'h55);
        repeat (10) step();

        // Six bytes with valid held: FIFO fills to 4
        maxc[0] = 0;
        for (int b = 1; b <= 6; b++) pend[0].push_back(8'(b * 17));
        wait_rx(0, 10, 600);
        for (int b = 1; b <= 6; b++) chk("fill_byte", 0, int'(rxq[0][3+b]), b * 17);
        chk("fill_max_count", 0, maxc[0], 4);
        repeat (10) step();

        // Parity: 0x07 -> 1, 0x03 -> 0, 44-cycle frames
        pend[1].push_back(8'h07); pend[1].push_back(8'h03);
        wait_rx(1, 2, 300);
        chk("par_byte0", 1, int'(rxq[1][0]), 32'h07);
        chk("par_bit0", 1, int'(rxp[1][0]), 1);
        chk("par_byte1", 1, int'(rxq[1][1]), 32'h03);
        chk("par_bit1", 1, int'(rxp[1][1]), 0);
        repeat (6) step();
        chk("par_frame_len", 1, last_len[1], 44);

        // Reset during data bit 3, then 0x3C
        pend[0].push_back(8'h81);
        for (int t = 0; t < 100 && !(s_act[0] && cyc - s_k[0] >= 17); t++) step();
        chk("reached_data_bit3", 0, int'(s_act[0]), 1);
        rst_req[0] = 1'b1;
        step();
        rst_req[0] = 1'b0;
        #1;
        chk("midrst_tx_out", 0, int'(txo[0]), 1);
        chk("midrst_busy", 0, int'(bsy[0]), 0);
        chk("midrst_count", 0, int'(fc[0]), 0);
        repeat (4) step();
        pend[0].push_back(8'h3C);
        wait_rx(0, 11, 200);
        chk("post_rst_byte", 0, int'(rxq[0][10]), 32'h3C);

        // Random bytes with valid gaps at CPB=100
        gap_rand[2] = 1'b1;
        for (int n = 0; n < 30; n++) begin
            sent.push_back(8'($urandom_range(0, 255)));
            pend[2].push_back(sent[n]);
        end
        wait_rx(2, 30, 40000);
        for (int n = 0; n < 30 && n < rxq[2].size(); n++) chk("rand_byte", 2, int'(rxq[2][n]), int'(sent[n]));
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
